rsa_frame_ctrl: RTL and testbench

RSA_FRAME_CTRL -- requirements
Module: rsa_frame_ctrl

---
 rtl/rsa_pkg.sv | 18 +
 rtl/rsa_frame_ctrl.sv | 175 +++++++++++++++++
 tb/tb_rsa_frame_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA frame controller: FSM state encoding and protocol bytes.
package rsa_pkg;

    typedef enum logic [2:0] {
        RX_SYNC = 3'd0,
        RX_BODY = 3'd1,
        CHECK   = 3'd2,
        LAUNCH  = 3'd3,
        WAIT    = 3'd4,
        TX_STAT = 3'd5,
        TX_RES  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h5A;
    localparam logic [7:0] STAT_OK     = 8'h00;
    localparam logic [7:0] STAT_BADMOD = 8'hE1;

endpackage

// File: rtl/rsa_frame_ctrl.sv
// Byte-stream framing around a modexp core: assembles m/e/n, launches the core,
// and returns a status byte followed by the result (MSB first).
module rsa_frame_ctrl
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] core_m,
    output logic [WIDTH-1:0] core_e,
    output logic [WIDTH-1:0] core_n,
    output logic             core_start,
    input  logic [WIDTH-1:0] core_out,
    input  logic             core_busy,
    input  logic             core_done,
    output logic             frame_err
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned ABITS  = 3 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(3 * NBYTES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ABITS-1:0]   asm_q, asm_d;
    logic [7:0]         status_q, status_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0]   m_d, e_d, n_d;
    logic [7:0]         tx_data_d;
    logic               tx_valid_d, rx_ready_d, core_start_d, frame_err_d;
    logic               rx_fire, tx_fire;

    assign rx_fire = rx_valid && rx_ready;
    assign tx_fire = tx_valid && tx_ready;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RX_SYNC;
            cnt_q      <= '0;
            asm_q      <= '0;
            status_q   <= '0;
            result_q   <= '0;
            tx_sh_q    <= '0;
            core_m     <= '0;
            core_e     <= '0;
            core_n     <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            rx_ready   <= 1'b0;
            core_start <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            status_q   <= status_d;
            result_q   <= result_d;
            tx_sh_q    <= tx_sh_d;
            core_m     <= m_d;
            core_e     <= e_d;
            core_n     <= n_d;
            tx_data    <= tx_data_d;
            tx_valid   <= tx_valid_d;
            rx_ready   <= rx_ready_d;
            core_start <= core_start_d;
            frame_err  <= frame_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        status_d     = status_q;
        result_d     = result_q;
        tx_sh_d      = tx_sh_q;
        m_d          = core_m;
        e_d          = core_e;
        n_d          = core_n;
        tx_data_d    = tx_data;
        tx_valid_d   = tx_valid;
        core_start_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            RX_SYNC: begin
                if (rx_fire && rx_data == SYNC_BYTE) begin
                    state_d = RX_BODY;
                    cnt_d   = '0;
                end
            end
            RX_BODY: begin
                if (rx_fire) begin
                    asm_d = {asm_q[ABITS-9:0], rx_data};
                    if (cnt_q == CNT_W'(3 * NBYTES - 1)) begin
                        state_d = CHECK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                m_d = asm_q[3*WIDTH-1 -: WIDTH];
                e_d = asm_q[2*WIDTH-1 -: WIDTH];
                n_d = asm_q[WIDTH-1:0];
                if (asm_q[WIDTH-1:0] < WIDTH'(2)) begin
                    frame_err_d = 1'b1;
                    status_d    = STAT_BADMOD;
                    tx_data_d   = STAT_BADMOD;
                    tx_valid_d  = 1'b1;
                    state_d     = TX_STAT;
                end else begin
                    status_d = STAT_OK;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                // Only start an idle core so the start pulse is never missed
                if (!core_busy && !core_done) begin
                    core_start_d = 1'b1;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (core_done) begin
                    result_d   = core_out;
                    tx_data_d  = status_q;
                    tx_valid_d = 1'b1;
                    state_d    = TX_STAT;
                end
            end
            TX_STAT: begin
                if (tx_fire) begin
                    if (status_q == STAT_OK) begin
                        tx_data_d = result_q[WIDTH-1 -: 8];
                        tx_sh_d   = result_q << 8;
                        cnt_d     = '0;
                        state_d   = TX_RES;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = RX_SYNC;
                    end
                end
            end
            TX_RES: begin
                if (tx_fire) begin
                    if (cnt_q == CNT_W'(NBYTES - 1)) begin
                        tx_valid_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = RX_SYNC;
                    end else begin
                        tx_data_d = tx_sh_q[WIDTH-1 -: 8];
                        tx_sh_d   = tx_sh_q << 8;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = RX_SYNC;
        endcase

        rx_ready_d = (state_d == RX_SYNC) || (state_d == RX_BODY);
    end

endmodule

// File: tb/tb_rsa_frame_ctrl.sv
// Directed bench for rsa_frame_ctrl with a small behavioural modexp core beside it.
module tb_rsa_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] core_m, core_e, core_n, core_out;
    logic        core_start, core_busy, core_done, frame_err;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int ferr_cnt = 0;
    int lat_cnt;
    int base_start, base_ferr;

    always #5 clk = ~clk;

    rsa_frame_ctrl #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .core_m     (core_m),
        .core_e     (core_e),
        .core_n     (core_n),
        .core_start (core_start),
        .core_out   (core_out),
        .core_busy  (core_busy),
        .core_done  (core_done),
        .frame_err  (frame_err)
    );

    function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] e,
                                           input logic [15:0] n);
        longint r = 1;
        longint x = longint'(b) % longint'(n);
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = (r * x) % longint'(n);
            x = (x * x) % longint'(n);
        end
        return 16'(r % longint'(n));
    endfunction

    // Behavioural core: busy for a few cycles after start, then a one-cycle done
    logic [15:0] core_res;
    int          core_wait;
    always @(posedge clk) begin
        if (!rst) begin
            core_busy <= 1'b0;
            core_done <= 1'b0;
            core_out  <= '0;
            core_wait <= 0;
        end else if (core_start) begin
            core_busy <= 1'b1;
            core_done <= 1'b0;
            core_wait <= 4;
            core_res  <= modexp(core_m, core_e, core_n);
            start_cnt <= start_cnt + 1;
        end else if (core_busy) begin
            if (core_wait == 0) begin
                core_busy <= 1'b0;
                core_done <= 1'b1;
                core_out  <= core_res;
            end else begin
                core_wait <= core_wait - 1;
            end
        end else begin
            core_done <= 1'b0;
        end
    end

    always @(posedge clk) if (rst && frame_err) ferr_cnt <= ferr_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n);
        send_byte(8'h5A);
        send_byte(m[15:8]); send_byte(m[7:0]);
        send_byte(e[15:8]); send_byte(e[7:0]);
        send_byte(n[15:8]); send_byte(n[7:0]);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input string tag, input int stall);
        int n = 0;
        logic [7:0] held;
        logic stable = 1'b1;
        @(negedge clk);
        while (!tx_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) check({tag, "_timeout"}, 64'(tx_valid), 64'd1);
        held = tx_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (tx_data !== held || tx_valid !== 1'b1) stable = 1'b0;
        end
        if (stall > 0) check({tag, "_stable"}, 64'(stable), 64'd1);
        tx_ready = 1'b1;
        check(tag, 64'(tx_data), 64'(exp));
        @(posedge clk);
        #1 tx_ready = 1'b0;
    endtask

    task automatic expect_idle_tx(input string tag);
        @(negedge clk);
        check(tag, 64'(tx_valid), 64'd0);
    endtask

    initial begin
        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_outs", {tx_valid, core_start, frame_err, tx_data}, 64'd0);
        check("rst_core_ops", {core_m, core_e, core_n}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rx_ready_after_rst", 64'(rx_ready), 64'd1);

        // m=65 e=17 n=3233, with launch and response latency checks
        send_frame(16'd65, 16'd17, 16'd3233);
        @(negedge clk); check("lat_check_cycle", 64'(core_start), 64'd0);
        @(negedge clk); check("lat_launch_cycle", 64'(core_start), 64'd0);
        @(negedge clk); check("lat_start_pulse", 64'(core_start), 64'd1);
        check("core_ops_1", {core_m, core_e, core_n}, {16'd65, 16'd17, 16'd3233});
        @(negedge clk); check("start_one_cycle", 64'(core_start), 64'd0);
        lat_cnt = 0;
        while (!core_done && lat_cnt < 100) begin
            @(negedge clk);
            lat_cnt++;
        end
        check("done_seen", 64'(core_done), 64'd1);
        check("tx_valid_at_done", 64'(tx_valid), 64'd0);
        @(negedge clk); check("tx_valid_after_done", 64'(tx_valid), 64'd1);
        recv_byte(8'h00, "f1_stat", 0);
        recv_byte(8'h0A, "f1_res_hi", 0);
        recv_byte(8'hE6, "f1_res_lo", 0);
        expect_idle_tx("f1_no_extra");
        check("f1_starts", 64'(start_cnt), 64'd1);

        // Decrypt back, with tx_ready stalled 10 cycles per byte
        send_frame(16'd2790, 16'd2753, 16'd3233);
        recv_byte(8'h00, "f2_stat", 10);
        recv_byte(8'h00, "f2_res_hi", 10);
        recv_byte(8'h41, "f2_res_lo", 10);
        expect_idle_tx("f2_no_extra");

        // Garbage before sync is discarded
        base_start = start_cnt;
        send_byte(8'h13);
        send_byte(8'h37);
        send_frame(16'd65, 16'd17, 16'd3233);
        recv_byte(8'h00, "f3_stat", 0);
        recv_byte(8'h0A, "f3_res_hi", 0);
        recv_byte(8'hE6, "f3_res_lo", 0);
        expect_idle_tx("f3_no_extra");
        check("f3_one_start", 64'(start_cnt - base_start), 64'd1);

        // e=0 passes straight through: 5^0 mod 7 = 1
        send_frame(16'd5, 16'd0, 16'd7);
        recv_byte(8'h00, "f4_stat", 0);
        recv_byte(8'h00, "f4_res_hi", 0);
        recv_byte(8'h01, "f4_res_lo", 0);
        check("f4_core_e", 64'(core_e), 64'd0);

        // Bad modulus n=1
        base_start = start_cnt;
        base_ferr  = ferr_cnt;
        send_frame(16'd65, 16'd17, 16'd1);
        recv_byte(8'hE1, "f5_stat", 0);
        repeat (5) expect_idle_tx("f5_no_result");
        check("f5_ferr", 64'(ferr_cnt - base_ferr), 64'd1);
        check("f5_no_start", 64'(start_cnt - base_start), 64'd0);
        check("f5_core_n", 64'(core_n), 64'd1);

        // Reset after 4 body bytes, then a full frame
        send_byte(8'h5A);
        send_byte(8'h00); send_byte(8'h41); send_byte(8'h00); send_byte(8'h11);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_outs", {tx_valid, core_start, frame_err, rx_ready, tx_data}, 64'd0);
        check("mid_rst_core_ops", {core_m, core_e, core_n}, 64'd0);
        rst = 1'b1;
        base_start = start_cnt;
        send_frame(16'd2790, 16'd2753, 16'd3233);
        recv_byte(8'h00, "f6_stat", 0);
        recv_byte(8'h00, "f6_res_hi", 0);
        recv_byte(8'h41, "f6_res_lo", 0);
        expect_idle_tx("f6_no_extra");
        check("f6_one_start", 64'(start_cnt - base_start), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
